// File: rtl/sound_sequencer.sv
// Collision sound sequencer: plays fixed note sequences and drives the tone oscillator.
// Build option: define SOUND_SAW_EN for a sawtooth wave; otherwise a square wave is produced.

typedef enum logic {OFF = 1'b0, ON = 1'b1} MODE_TYPES;

module sound_sequencer #(
    parameter int unsigned NOTE_CYCLES = 2500000,
    parameter int unsigned GAP_CYCLES  = 250000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       good_collision,
    input  logic       bad_collision,
    input  logic       at_max,
    output logic [8:0] freq,
    output MODE_TYPES  state,
    output logic       playSound,
    output logic [7:0] wave,
    output logic       busy
);

    localparam int unsigned MaxCycles = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int unsigned TW        = $clog2(MaxCycles) + 1;

    localparam logic [TW-1:0] NoteLast = TW'(NOTE_CYCLES - 1);
    localparam logic [TW-1:0] GapLast  = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} seq_state_t;

    seq_state_t    fsm_q, fsm_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    idx_q, idx_d;
    logic          seq_bad_q, seq_bad_d;
    logic [7:0]    phase_q, phase_d;
    logic [1:0]    last_idx;
    logic          restart;
    logic [8:0]    note_freq;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fsm_q     <= IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            seq_bad_q <= 1'b0;
            phase_q   <= '0;
        end else begin
            fsm_q     <= fsm_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            seq_bad_q <= seq_bad_d;
            phase_q   <= phase_d;
        end
    end

    assign last_idx = seq_bad_q ? 2'd2 : 2'd1;

    always_comb begin
        fsm_d     = fsm_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        seq_bad_d = seq_bad_q;
        restart   = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (bad_collision || good_collision) begin
                    fsm_d     = PLAY;
                    seq_bad_d = bad_collision;
                    idx_d     = '0;
                    timer_d   = '0;
                end
            end
            PLAY: begin
                if (timer_q == NoteLast) begin
                    timer_d = '0;
                    if (idx_q == last_idx) begin
                        fsm_d = IDLE;
                        idx_d = '0;
                    end else begin
                        fsm_d = GAP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GAP: begin
                if (timer_q == GapLast) begin
                    fsm_d   = PLAY;
                    idx_d   = idx_q + 2'd1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        // A game-over request pre-empts an apple sequence in progress.
        if (fsm_q != IDLE && bad_collision && !seq_bad_q) begin
            restart   = 1'b1;
            fsm_d     = PLAY;
            seq_bad_d = 1'b1;
            idx_d     = '0;
            timer_d   = '0;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (fsm_d == PLAY && (fsm_q != PLAY || restart)) begin
            phase_d = '0;
        end else if (fsm_q == PLAY && at_max) begin
            phase_d = phase_q + 8'd1;
        end
    end

    always_comb begin
        note_freq = 9'd0;
        case ({seq_bad_q, idx_q})
            3'b0_00: note_freq = 9'd262;
            3'b0_01: note_freq = 9'd392;
            3'b1_00: note_freq = 9'd330;
            3'b1_01: note_freq = 9'd262;
            3'b1_10: note_freq = 9'd196;
            default: note_freq = 9'd0;
        endcase
    end

    always_comb begin
        freq      = 9'd0;
        state     = OFF;
        playSound = 1'b0;
        wave      = 8'h00;
        if (fsm_q == PLAY) begin
            freq      = note_freq;
            state     = ON;
            playSound = 1'b1;
`ifdef SOUND_SAW_EN
            wave      = phase_q;
`else
            wave      = phase_q[7] ? 8'hFF : 8'h00;
`endif
        end
    end

    assign busy = (fsm_q != IDLE);

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with a per-cycle scoreboard of expected outputs.
`timescale 1ns/1ps

module tb_sound_sequencer;

    localparam int NOTE = 20;
    localparam int GAP  = 5;

    typedef struct packed {
        logic [8:0] freq;
        logic       play;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       nRst;
    logic       good, bad, at_max;
    logic [8:0] freq;
    logic       state;
    logic       playSound;
    logic [7:0] wave;
    logic       busy;

    logic       good_l, bad_l, at_max_l;
    logic [8:0] freq_l;
    logic       state_l;
    logic       playSound_l;
    logic [7:0] wave_l;
    logic       busy_l;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    sound_sequencer #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP)) dut (
        .clk            (clk),
        .nRst           (nRst),
        .good_collision (good),
        .bad_collision  (bad),
        .at_max         (at_max),
        .freq           (freq),
        .state          (state),
        .playSound      (playSound),
        .wave           (wave),
        .busy           (busy)
    );

    // Long notes so the 8-bit phase can wrap within a single note.
    sound_sequencer #(.NOTE_CYCLES(400), .GAP_CYCLES(GAP)) dut_long (
        .clk            (clk),
        .nRst           (nRst),
        .good_collision (good_l),
        .bad_collision  (bad_l),
        .at_max         (at_max_l),
        .freq           (freq_l),
        .state          (state_l),
        .playSound      (playSound_l),
        .wave           (wave_l),
        .busy           (busy_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] note_of(input bit is_bad, input int k);
        logic [8:0] f;
        if (is_bad) f = (k == 0) ? 9'd330 : (k == 1) ? 9'd262 : 9'd196;
        else        f = (k == 0) ? 9'd262 : 9'd392;
        return f;
    endfunction

    task automatic push_seq(input bit is_bad);
        int n;
        logic [8:0] f;
        n = is_bad ? 3 : 2;
        for (int k = 0; k < n; k++) begin
            f = note_of(is_bad, k);
            if (k > 0) repeat (GAP) sb.push_back('{freq: 9'd0, play: 1'b0, busy: 1'b1});
            repeat (NOTE) sb.push_back('{freq: f, play: 1'b1, busy: 1'b1});
        end
    endtask

    task automatic check_main();
        exp_t e;
        e = '{freq: 9'd0, play: 1'b0, busy: 1'b0};
        if (sb.size() > 0) e = sb.pop_front();
        chk("freq", freq, e.freq);
        chk("playSound", playSound, e.play);
        chk("state", state, e.play);
        chk("busy", busy, e.busy);
        chk("wave", wave, 0);
    endtask

    task automatic chk_long(input logic [8:0] f, input int i);
        logic [7:0] ph;
        logic [7:0] w;
        ph = 8'(i % 256);
`ifdef SOUND_SAW_EN
        w = ph;
`else
        w = ph[7] ? 8'hFF : 8'h00;
`endif
        chk("long_freq", freq_l, f);
        chk("long_wave", wave_l, w);
        chk("long_busy", busy_l, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        good   = 1'b0;
        bad    = 1'b0;
        good_l = 1'b0;
        bad_l  = 1'b0;
        check_main();
    endtask

    initial begin
        nRst = 1'b1; good = 1'b0; bad = 1'b0; at_max = 1'b0;
        good_l = 1'b0; bad_l = 1'b0; at_max_l = 1'b0;
        #2 nRst = 1'b0;
        #1 check_main();
        repeat (2) tick();
        nRst = 1'b1;
        repeat (3) tick();

        // Apple sequence: 262, gap, 392, then idle.
        push_seq(1'b0);
        good = 1'b1;
        repeat (NOTE * 2 + GAP + 3) tick();

        // Simultaneous requests: game-over wins, 70 busy cycles.
        push_seq(1'b1);
        good = 1'b1;
        bad  = 1'b1;
        repeat (72) tick();

        // Game-over pre-empts apple at cycle 8; later requests are ignored.
        push_seq(1'b0);
        good = 1'b1;
        repeat (8) tick();
        sb.delete();
        push_seq(1'b1);
        bad = 1'b1;
        tick();
        repeat (5) tick();
        good = 1'b1;
        tick();
        repeat (10) tick();
        bad = 1'b1;
        tick();
        repeat (60) tick();

        // Reset mid-gap of game-over, request during reset is lost.
        push_seq(1'b1);
        bad = 1'b1;
        repeat (NOTE + 2) tick();
        nRst = 1'b0;
        sb.delete();
        #1 check_main();
        good = 1'b1;
        tick();
        nRst = 1'b1;
        tick();
        push_seq(1'b0);
        good = 1'b1;
        repeat (NOTE * 2 + GAP + 2) tick();

        // Phase: counts every at_max PLAY cycle, wraps, clears on pre-emption.
        at_max_l = 1'b1;
        good_l   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            chk_long(9'd262, i);
        end
        bad_l = 1'b1;
        for (int i = 0; i <= 300; i++) begin
            tick();
            chk_long(9'd330, i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
